// File: rtl/m68k_bus_target.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | m68k_bus_target                                                            |
// | 68000-bus responder serving a 16-bit word bank inside a fixed window and   |
// | terminating cycles with nDTACK (or nBERR when M68K_TARGET_BERR_EN is set). |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module m68k_bus_target #(
  parameter logic [23:0] BASE_ADDR   = 24'hE90000,
  parameter int          WIN_AW      = 4,
  parameter int          WAIT_STATES = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              nAS_IN,
  input  logic              nUDS_IN,
  input  logic              nLDS_IN,
  input  logic              RnW_IN,
  input  logic [2:0]        FC_IN,
  input  logic [23:1]       A_IN,
  input  logic [15:0]       D_IN,
  output logic [15:0]       D_OUT,
  output logic              D_OE,
  output logic              nDTACK_OE,
  output logic              nBERR_OE,
  input  logic [WIN_AW-1:0] lcl_addr,
  input  logic              lcl_wr,
  input  logic [15:0]       lcl_wdata,
  output logic [15:0]       lcl_rdata,
  output logic              bus_wr_evt,
  output logic [WIN_AW-1:0] bus_wr_word
);

  localparam int c_WORDS = 2 ** WIN_AW;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DECODE  = 3'd1,
    S_WAIT_DS = 3'd2,
    S_WAIT    = 3'd3,
    S_ACK     = 3'd4,
    S_HOLD    = 3'd5
  } state_t;

  state_t r_state, w_state_nx;

  logic [1:0]        r_as_sync, r_uds_sync, r_lds_sync, r_rnw_sync;
  logic [23:1]       r_a_s1, r_a_s2;
  logic [15:0]       r_d_s1, r_d_s2;
  logic [15:0]       r_bank [c_WORDS];
  logic [WIN_AW-1:0] r_idx;
  logic [3:0]        r_cnt;
  logic              r_uds_l, r_lds_l, r_rnw_l;
  logic              r_doe, r_dtack, r_berr, r_wr_evt;
  logic [15:0]       r_dout, r_lcl_rdata;
  logic [WIN_AW-1:0] r_wr_word;

  logic w_as_n, w_ds_any, w_hit, w_user, w_commit;
  logic w_decode, w_latch_ds, w_to_ack, w_release, w_cnt_dec;

`ifdef M68K_TARGET_BERR_EN
  logic [1:0] r_fc2_sync;
  logic       r_user;
  wire        w_unused_fc = ^FC_IN[1:0];
  assign w_user = r_user;
`else
  wire        w_unused_fc = ^FC_IN;
  assign w_user = 1'b0;
`endif

  assign w_as_n   = r_as_sync[1];
  assign w_ds_any = ~r_uds_sync[1] | ~r_lds_sync[1];
  assign w_hit    = (r_a_s2[23:WIN_AW+1] == BASE_ADDR[23:WIN_AW+1]);
  assign w_commit = w_to_ack & ~r_rnw_l & ~w_user;

  // Two-flop synchronizers; strobes reset to their negated (high) level.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_as_sync  <= 2'b11;
      r_uds_sync <= 2'b11;
      r_lds_sync <= 2'b11;
      r_rnw_sync <= 2'b11;
      r_a_s1     <= '0;
      r_a_s2     <= '0;
      r_d_s1     <= '0;
      r_d_s2     <= '0;
    end else begin
      r_as_sync  <= {r_as_sync[0], nAS_IN};
      r_uds_sync <= {r_uds_sync[0], nUDS_IN};
      r_lds_sync <= {r_lds_sync[0], nLDS_IN};
      r_rnw_sync <= {r_rnw_sync[0], RnW_IN};
      r_a_s1     <= A_IN;
      r_a_s2     <= r_a_s1;
      r_d_s1     <= D_IN;
      r_d_s2     <= r_d_s1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= S_IDLE;
    else         r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_decode   = 1'b0;
    w_latch_ds = 1'b0;
    w_to_ack   = 1'b0;
    w_release  = 1'b0;
    w_cnt_dec  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_as_n) w_state_nx = S_DECODE;
      end
      S_DECODE: begin
        if (w_as_n) begin
          w_release  = 1'b1;
          w_state_nx = S_IDLE;
        end else begin
          w_decode   = 1'b1;
          w_state_nx = w_hit ? S_WAIT_DS : S_HOLD;
        end
      end
      S_WAIT_DS: begin
        if (w_as_n) begin
          w_release  = 1'b1;
          w_state_nx = S_IDLE;
        end else if (w_ds_any) begin
          w_latch_ds = 1'b1;
          w_state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_as_n) begin
          w_release  = 1'b1;
          w_state_nx = S_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_to_ack   = 1'b1;
          w_state_nx = S_ACK;
        end else begin
          w_cnt_dec  = 1'b1;
        end
      end
      S_ACK: begin
        w_state_nx = S_HOLD;
      end
      S_HOLD: begin
        if (w_as_n) begin
          w_release  = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      default: begin
        w_release  = 1'b1;
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_idx     <= '0;
      r_cnt     <= '0;
      r_uds_l   <= 1'b0;
      r_lds_l   <= 1'b0;
      r_rnw_l   <= 1'b1;
      r_doe     <= 1'b0;
      r_dtack   <= 1'b0;
      r_berr    <= 1'b0;
      r_dout    <= '0;
      r_wr_evt  <= 1'b0;
      r_wr_word <= '0;
`ifdef M68K_TARGET_BERR_EN
      r_fc2_sync <= 2'b00;
      r_user     <= 1'b0;
`endif
    end else begin
`ifdef M68K_TARGET_BERR_EN
      r_fc2_sync <= {r_fc2_sync[0], FC_IN[2]};
      if (w_decode) r_user <= ~r_fc2_sync[1];
`endif
      r_wr_evt <= w_commit;
      if (w_latch_ds) begin
        r_uds_l <= ~r_uds_sync[1];
        r_lds_l <= ~r_lds_sync[1];
        r_rnw_l <= r_rnw_sync[1];
        r_idx   <= r_a_s2[WIN_AW:1];
        r_cnt   <= 4'(WAIT_STATES);
        // Read data is frozen here; later bank writes do not disturb this cycle.
        if (r_rnw_sync[1] && !w_user) begin
          r_dout <= r_bank[r_a_s2[WIN_AW:1]];
          r_doe  <= 1'b1;
        end
      end
      if (w_cnt_dec) r_cnt <= r_cnt - 4'd1;
      if (w_to_ack) begin
        if (w_user) r_berr  <= 1'b1;
        else        r_dtack <= 1'b1;
      end
      if (w_commit) r_wr_word <= r_idx;
      if (w_release) begin
        r_doe   <= 1'b0;
        r_dtack <= 1'b0;
        r_berr  <= 1'b0;
      end
    end
  end

  // Bus commit takes the strobed lanes; any unstrobed lane of the same word
  // still accepts a coincident local write.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < c_WORDS; i++) r_bank[i] <= '0;
      r_lcl_rdata <= '0;
    end else begin
      r_lcl_rdata <= r_bank[lcl_addr];
      for (int i = 0; i < c_WORDS; i++) begin
        if (w_commit && (r_idx == WIN_AW'(i))) begin
          if (r_uds_l)
            r_bank[i][15:8] <= r_d_s2[15:8];
          else if (lcl_wr && (lcl_addr == WIN_AW'(i)))
            r_bank[i][15:8] <= lcl_wdata[15:8];
          if (r_lds_l)
            r_bank[i][7:0] <= r_d_s2[7:0];
          else if (lcl_wr && (lcl_addr == WIN_AW'(i)))
            r_bank[i][7:0] <= lcl_wdata[7:0];
        end else if (lcl_wr && (lcl_addr == WIN_AW'(i))) begin
          r_bank[i] <= lcl_wdata;
        end
      end
    end
  end

  assign D_OUT       = r_dout;
  assign D_OE        = r_doe;
  assign nDTACK_OE   = r_dtack;
`ifdef M68K_TARGET_BERR_EN
  assign nBERR_OE    = r_berr;
`else
  assign nBERR_OE    = 1'b0;
  wire   w_unused_berr = r_berr;
`endif
  assign lcl_rdata   = r_lcl_rdata;
  assign bus_wr_evt  = r_wr_evt;
  assign bus_wr_word = r_wr_word;

endmodule
`default_nettype wire
